// File: rtl/wait_event_pkg.sv
// wait_event_pkg: shared types for the multi-channel wait-event block.
// Mode and state encodings plus a legality helper for command decode.
package wait_event_pkg;

    typedef enum logic [2:0] {
        LEVEL_HIGH = 3'd0,
        LEVEL_LOW  = 3'd1,
        RISE       = 3'd2,
        FALL       = 3'd3,
        EQ         = 3'd4,
        NEQ        = 3'd5
    } wait_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } wait_state_t;

    function automatic logic is_legal_mode(input logic [2:0] mode);
        return (mode <= 3'd5);
    endfunction

endpackage

// File: rtl/wait_cond_eval.sv
// wait_cond_eval: combinational completion test for one watched channel.
// Level/edge modes treat value as a mask; EQ/NEQ compare against it.
module wait_cond_eval
    import wait_event_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] prev,
    input  wait_mode_t       mode,
    input  logic [WIDTH-1:0] value,
    output logic             met
);

    logic cur_any;
    logic prev_any;

    assign cur_any  = |(cur & value);
    assign prev_any = |(prev & value);

    // Pick the condition that matches the latched wait mode
    always_comb begin
        met = 1'b0;
        case (mode)
            LEVEL_HIGH: met = cur_any;
            LEVEL_LOW:  met = !cur_any;
            RISE:       met = !prev_any && cur_any;
            FALL:       met = prev_any && !cur_any;
            EQ:         met = (cur == value);
            NEQ:        met = (cur != value);
            default:    met = 1'b0;
        endcase
    end

endmodule

// File: rtl/wait_event_multi.sv
// wait_event_multi: command-driven wait on one of WAIT_SIZE bench signals.
// Reports a registered done pulse, timeout flag and elapsed cycle count.
module wait_event_multi
    import wait_event_pkg::*;
#(
    parameter int WAIT_SIZE     = 8,
    parameter int WAIT_WIDTH    = 1,
    parameter int TIMEOUT_WIDTH = 32,
    localparam int SEL_WIDTH    = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_sel_wait,
    input  logic                     i_args_valid,
    input  logic [SEL_WIDTH-1:0]     i_wait_idx,
    input  logic [2:0]               i_wait_mode,
    input  logic [WAIT_WIDTH-1:0]    i_wait_value,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
    input  logic [WAIT_WIDTH-1:0]    i_wait [WAIT_SIZE],
    output logic                     o_busy,
    output logic                     o_wait_done,
    output logic                     o_timeout,
    output logic                     o_err,
    output logic [TIMEOUT_WIDTH-1:0] o_cycle_count
);

    wait_state_t              state;
    wait_state_t              state_n;

    logic [WAIT_WIDTH-1:0]    s_wait [WAIT_SIZE];
    logic [WAIT_WIDTH-1:0]    s_prev;
    logic [SEL_WIDTH-1:0]     idx_q;
    wait_mode_t               mode_q;
    logic [WAIT_WIDTH-1:0]    value_q;
    logic [TIMEOUT_WIDTH-1:0] timeout_q;
    logic [TIMEOUT_WIDTH-1:0] counter;

    logic [WAIT_WIDTH-1:0]    chan;
    logic [WAIT_WIDTH-1:0]    arm_chan;
    logic                     met;
    logic                     cmd;
    logic                     cmd_legal;
    logic                     last_cycle;

    logic                     accept;
    logic                     err_n;
    logic                     done_n;
    logic                     to_n;
    logic                     cc_load;
    logic [TIMEOUT_WIDTH-1:0] cc_n;
    logic                     cnt_inc;

    assign cmd       = i_sel_wait & i_args_valid;
    assign cmd_legal = (int'(i_wait_idx) < WAIT_SIZE) &&
                       is_legal_mode(i_wait_mode);
    assign last_cycle = (timeout_q != '0) &&
                        (counter == timeout_q - TIMEOUT_WIDTH'(1));

    // Channel muxes: active channel while armed, requested channel at arm
    always_comb begin
        chan     = '0;
        arm_chan = '0;
        for (int i = 0; i < WAIT_SIZE; i++) begin
            if (idx_q == SEL_WIDTH'(i))
                chan = s_wait[i];
            if (i_wait_idx == SEL_WIDTH'(i))
                arm_chan = s_wait[i];
        end
    end

    wait_cond_eval #(
        .WIDTH (WAIT_WIDTH)
    ) u_eval (
        .cur   (chan),
        .prev  (s_prev),
        .mode  (mode_q),
        .value (value_q),
        .met   (met)
    );

    // Next-state and registered-output decisions for the wait FSM
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        err_n   = 1'b0;
        done_n  = 1'b0;
        to_n    = 1'b0;
        cc_load = 1'b0;
        cc_n    = counter;
        cnt_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd) begin
                    if (cmd_legal) begin
                        accept  = 1'b1;
                        state_n = ARMED;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ARMED: begin
                err_n = cmd;
                if (met) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    cc_load = 1'b1;
                    cc_n    = counter;
                end else if (last_cycle) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    to_n    = 1'b1;
                    cc_load = 1'b1;
                    cc_n    = timeout_q;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                err_n   = cmd;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Input stage, command latches, edge history and elapsed counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WAIT_SIZE; i++)
                s_wait[i] <= '0;
            s_prev    <= '0;
            idx_q     <= '0;
            mode_q    <= LEVEL_HIGH;
            value_q   <= '0;
            timeout_q <= '0;
            counter   <= '0;
        end else begin
            s_wait <= i_wait;
            if (accept) begin
                idx_q     <= i_wait_idx;
                mode_q    <= wait_mode_t'(i_wait_mode);
                value_q   <= i_wait_value;
                timeout_q <= i_timeout;
                counter   <= '0;
                s_prev    <= arm_chan;
            end else if (state == ARMED) begin
                s_prev <= chan;
                if (cnt_inc && (counter != '1))
                    counter <= counter + TIMEOUT_WIDTH'(1);
            end
        end
    end

    // Registered outputs; cycle count is cleared on arm and set on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_busy        <= 1'b0;
            o_wait_done   <= 1'b0;
            o_timeout     <= 1'b0;
            o_err         <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            o_busy      <= (state_n != IDLE);
            o_wait_done <= done_n;
            o_timeout   <= to_n;
            o_err       <= err_n;
            if (accept)
                o_cycle_count <= '0;
            else if (cc_load)
                o_cycle_count <= cc_n;
        end
    end

endmodule

// File: tb/tb_wait_event_multi.sv
// tb_wait_event_multi: directed scoreboard bench for wait_event_multi.
// Six channels of 8 bits so out-of-range indices are encodable.
module tb_wait_event_multi;
    import wait_event_pkg::*;

    localparam int WS = 6;
    localparam int WW = 8;
    localparam int TW = 32;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0;
    logic          valid = 1'b0;
    logic [SW-1:0] idx = '0;
    logic [2:0]    mode = '0;
    logic [WW-1:0] value = '0;
    logic [TW-1:0] timeout = '0;
    logic [WW-1:0] wv [WS];
    logic          busy;
    logic          done;
    logic          to;
    logic          err;
    logic [TW-1:0] cc;

    typedef struct {
        int            cyc;
        logic          to;
        logic [TW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            arm_cyc = 0;
    int            n_asserts = 0;
    int            n_fails = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic          done_to = 1'b0;
    logic [TW-1:0] done_cc = '0;

    always #5 clk = ~clk;

    wait_event_multi #(
        .WAIT_SIZE     (WS),
        .WAIT_WIDTH    (WW),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sel_wait    (sel),
        .i_args_valid  (valid),
        .i_wait_idx    (idx),
        .i_wait_mode   (mode),
        .i_wait_value  (value),
        .i_timeout     (timeout),
        .i_wait        (wv),
        .o_busy        (busy),
        .o_wait_done   (done),
        .o_timeout     (to),
        .o_err         (err),
        .o_cycle_count (cc)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_to  = to;
            done_cc  = cc;
        end
    endtask

    task automatic cmd(input logic [SW-1:0] i, input logic [2:0] m,
                       input logic [WW-1:0] v, input logic [TW-1:0] t);
        sel     = 1'b1;
        valid   = 1'b1;
        idx     = i;
        mode    = m;
        value   = v;
        timeout = t;
        step();
        sel   = 1'b0;
        valid = 1'b0;
    endtask

    task automatic arm(input string tag, input logic [SW-1:0] i,
                       input logic [2:0] m, input logic [WW-1:0] v,
                       input logic [TW-1:0] t, input int lat,
                       input logic eto, input logic [TW-1:0] ecnt);
        cmd(i, m, v, t);
        arm_cyc = cyc;
        sb.push_back('{arm_cyc + lat, eto, ecnt});
        chk({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic expect_done(input string tag, input int budget);
        exp_t e;
        int   b;
        b = budget;
        while (done_cnt == 0 && b > 0) begin
            step();
            b--;
        end
        chk({tag, "_pulses"}, 64'(done_cnt), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_cycle"}, 64'(done_cyc), 64'(e.cyc));
            chk({tag, "_timeout"}, 64'(done_to), 64'(e.to));
            chk({tag, "_count"}, 64'(done_cc), 64'(e.cnt));
        end
        step();
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_done_after"}, 64'(done), 64'd0);
        done_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < WS; i++)
            wv[i] = '0;
        wv[0] = 8'h01;
        wv[2] = 8'h01;

        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_timeout", 64'(to), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_count", 64'(cc), 64'd0);
        rst_n = 1'b1;
        step();
        step();

        arm("rise", 3, RISE, 8'h01, 0, 6, 1'b0, 5);
        repeat (4) step();
        wv[3] = 8'h01;
        expect_done("rise", 20);

        arm("rise_to", 2, RISE, 8'h01, 10, 10, 1'b1, 10);
        expect_done("rise_to", 30);

        arm("eq", 5, EQ, 8'hA5, 0, 4, 1'b0, 3);
        step();
        wv[5] = 8'hA4;
        step();
        wv[5] = 8'hA5;
        expect_done("eq", 20);

        arm("neq", 5, NEQ, 8'hA5, 0, 4, 1'b0, 3);
        step();
        step();
        wv[5] = 8'h5A;
        expect_done("neq", 20);

        arm("race", 1, LEVEL_HIGH, 8'h01, 4, 4, 1'b0, 3);
        step();
        step();
        wv[1] = 8'h01;
        expect_done("race", 20);

        cmd(7, LEVEL_HIGH, 8'h01, 0);
        chk("bad_idx_err", 64'(err), 64'd1);
        chk("bad_idx_busy", 64'(busy), 64'd0);
        step();
        chk("bad_idx_err_clr", 64'(err), 64'd0);
        cmd(0, 3'd7, 8'h01, 0);
        chk("bad_mode7_err", 64'(err), 64'd1);
        chk("bad_mode7_busy", 64'(busy), 64'd0);
        step();
        cmd(0, 3'd6, 8'h01, 0);
        chk("bad_mode6_err", 64'(err), 64'd1);
        step();
        chk("bad_mode6_busy", 64'(busy), 64'd0);

        arm("busy_cmd", 0, FALL, 8'h01, 0, 4, 1'b0, 3);
        step();
        cmd(3, LEVEL_LOW, 8'h02, 0);
        chk("busy_cmd_err", 64'(err), 64'd1);
        chk("busy_cmd_busy", 64'(busy), 64'd1);
        wv[0] = 8'h00;
        expect_done("busy_cmd", 20);

        arm("abort", 4, RISE, 8'h01, 0, 0, 1'b0, 0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_timeout", 64'(to), 64'd0);
        chk("abort_count", 64'(cc), 64'd0);
        wv[4] = 8'h01;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        sb.delete();
        done_cnt = 0;

        arm("level_now", 4, LEVEL_HIGH, 8'h01, 0, 1, 1'b0, 0);
        expect_done("level_now", 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fails);
        $finish;
    end

endmodule
